calc_unit: RTL and testbench
============================

# calc_unit

Registered 4-bit integer calculator. Each enabled cycle it applies one of four operations (add, subtract, multiply, divide) to two unsigned 4-bit operands. It registers an 8-bit result with status flags one clock later. It is a leaf arithmetic block for simple datapaths and is controlled directly by a 2-bit opcode.

## Interface
- Parameters: none (widths fixed: operands 4 bits, result 8 bits).
- Clocking: one clock; reset is synchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: enable; operation is captured on a rising edge while high.
- `in1` in 4: operand A, unsigned.
- `in2` in 4: operand B, unsigned.
- `ops` in 2: opcode; 00 add, 01 sub, 10 mul, 11 div.
- `total` out 8: registered result.
- `valid` out 1: high for one cycle after each enabled capture.
- `neg` out 1: subtract result was negative (A < B).
- `dz` out 1: divide by zero.

## Operation
- Add: `total` = zero-extended A + B; range 0..30.
- Sub: `total` = (A − B) mod 256, i.e. 8-bit two's complement. `neg` = (A < B). Example: 3 − 8 gives 8'hFB with `neg` = 1.
- Mul: `total` = A × B; range 0..225; no overflow is possible.
- Div: `total` = floor(A / B), zero-extended.
  - B = 0: `total` = 8'hFF and `dz` = 1.
- `neg` is 0 for every op except sub. `dz` is 0 for every op except div.
- `en` low: `total`, `neg` and `dz` hold their values; `valid` = 0.
- Opcode decode is fully specified; there is no illegal-opcode state.

## Timing
- Reset value (when `rst_n` is low at a rising edge): `total` = 0, `valid` = 0, `neg` = 0, `dz` = 0. Reset overrides `en`.
- Latency 1 cycle: inputs sampled at edge N with `en` = 1 appear on all outputs after edge N.
- Throughput: one operation per cycle; back-to-back enabled cycles are allowed.
- `valid` is a single-cycle pulse per capture and stays high across consecutive enabled cycles.
- Reset asserted in the same cycle as `en`: the capture is discarded and outputs take reset values.
- No input handshake; inputs need only be stable around the sampling edge.

## Configuration
- Macro `CALC_DIV_EN`.
- Defined: division is implemented as described above.
- Undefined: divider logic is omitted. Opcode 11 produces `total` = 8'hFF and `dz` = 1 for any operands. All other ops are unchanged.

## Structure
- Shared package `calc_pkg`:
  - opcode enum `calc_op_e` (OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11);
  - width constants `CALC_IN_W` = 4 and `CALC_OUT_W` = 8;
  - constant `CALC_DZ_VAL` = 8'hFF.
- One sub-module, `calc_div`: combinational 4-bit restoring divider with inputs A and B, outputs quotient and dz. It is instantiated only under `CALC_DIV_EN`.
- The top level holds the opcode mux, adder/subtractor, multiplier and output registers.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `en` = 1 and `in1` = 5, `in2` = 7 → `total` = 0 and `valid`, `neg`, `dz` all 0.
- Add then sub, back to back:
  - cycle 1: 5 + 7 (op 00) → `total` = 12, `valid` = 1;
  - cycle 2: 8 − 3 (op 01) → `total` = 5, `neg` = 0.
- Negative sub and max add:
  - 3 − 8 → `total` = 8'hFB, `neg` = 1;
  - 15 + 15 → `total` = 30, `neg` = 0.
- Multiply:
  - 4 × 6 → `total` = 24;
  - 15 × 15 → `total` = 225.
- Divide:
  - 12 / 3 → `total` = 4;
  - 7 / 2 → `total` = 3;
  - 9 / 0 → `total` = 8'hFF, `dz` = 1.
  - Repeat the 12 / 3 case with `CALC_DIV_EN` undefined → `total` = 8'hFF, `dz` = 1.
- Enable hold: after 4 × 6, drop `en` and change the inputs to 1 + 1 → `total` stays 24 and `valid` = 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode, width and constant definitions for the calc_unit slice.
package calc_pkg;

  localparam int CALC_IN_W  = 4;
  localparam int CALC_OUT_W = 8;

  localparam logic [CALC_OUT_W-1:0] CALC_DZ_VAL = 8'hFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

endpackage

// File: rtl/calc_div.sv
// Combinational 4-bit restoring divider; only compiled when CALC_DIV_EN is defined.
`ifdef CALC_DIV_EN
module calc_div
  import calc_pkg::*;
(
  input  logic [CALC_IN_W-1:0] a,
  input  logic [CALC_IN_W-1:0] b,
  output logic [CALC_IN_W-1:0] quotient,
  output logic                 dz
);

  logic [CALC_IN_W:0] rem;

  always_comb begin
    rem      = '0;
    quotient = '0;
    for (int i = CALC_IN_W - 1; i >= 0; i--) begin
      rem = {rem[CALC_IN_W-1:0], a[i]};
      if (rem >= {1'b0, b}) begin
        rem         = rem - {1'b0, b};
        quotient[i] = 1'b1;
      end
    end
  end

  assign dz = (b == '0);

endmodule
`endif

// File: rtl/calc_unit.sv
// Registered 4-bit add/sub/mul/div calculator with one-cycle latency.
// Macro CALC_DIV_EN enables the divider; without it opcode 11 always reports divide-by-zero.
module calc_unit
  import calc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [CALC_IN_W-1:0]  in1,
  input  logic [CALC_IN_W-1:0]  in2,
  input  logic [1:0]            ops,
  output logic [CALC_OUT_W-1:0] total,
  output logic                  valid,
  output logic                  neg,
  output logic                  dz
);

  logic [CALC_OUT_W-1:0] a_ext;
  logic [CALC_OUT_W-1:0] b_ext;
  logic [CALC_OUT_W-1:0] div_total;
  logic                  div_dz;
  logic [CALC_OUT_W-1:0] nxt_total;
  logic                  nxt_neg;
  logic                  nxt_dz;

  assign a_ext = {{(CALC_OUT_W-CALC_IN_W){1'b0}}, in1};
  assign b_ext = {{(CALC_OUT_W-CALC_IN_W){1'b0}}, in2};

`ifdef CALC_DIV_EN
  logic [CALC_IN_W-1:0] quotient;
  logic                 q_dz;

  calc_div u_div (
    .a        (in1),
    .b        (in2),
    .quotient (quotient),
    .dz       (q_dz)
  );

  assign div_dz    = q_dz;
  assign div_total = q_dz ? CALC_DZ_VAL : {{(CALC_OUT_W-CALC_IN_W){1'b0}}, quotient};
`else
  assign div_dz    = 1'b1;
  assign div_total = CALC_DZ_VAL;
`endif

  always_comb begin
    nxt_total = '0;
    nxt_neg   = 1'b0;
    nxt_dz    = 1'b0;
    case (calc_op_e'(ops))
      OP_ADD: nxt_total = a_ext + b_ext;
      OP_SUB: begin
        nxt_total = a_ext - b_ext;
        nxt_neg   = (in1 < in2);
      end
      OP_MUL: nxt_total = a_ext * b_ext;
      OP_DIV: begin
        nxt_total = div_total;
        nxt_dz    = div_dz;
      end
      default: nxt_total = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total <= '0;
      valid <= 1'b0;
      neg   <= 1'b0;
      dz    <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        total <= nxt_total;
        neg   <= nxt_neg;
        dz    <= nxt_dz;
      end
    end
  end

endmodule

// File: tb/tb_calc_unit.sv
// Self-checking bench for calc_unit: directed cases then random traffic against an arithmetic model.
module tb_calc_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [1:0] ops;
  logic [7:0] total;
  logic       valid;
  logic       neg;
  logic       dz;

  int n_total = 0;
  int n_bad   = 0;

  int m_total = 0;
  int m_valid = 0;
  int m_neg   = 0;
  int m_dz    = 0;

  calc_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in1   (in1),
    .in2   (in2),
    .ops   (ops),
    .total (total),
    .valid (valid),
    .neg   (neg),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int r, input int e, input int a, input int b, input int op);
    if (r == 0) begin
      m_total = 0; m_valid = 0; m_neg = 0; m_dz = 0;
    end else begin
      m_valid = e;
      if (e != 0) begin
        m_neg = 0;
        m_dz  = 0;
        case (op)
          0: m_total = a + b;
          1: begin m_total = (a - b + 256) % 256; m_neg = (a < b) ? 1 : 0; end
          2: m_total = a * b;
          default: begin
`ifdef CALC_DIV_EN
            if (b == 0) begin m_total = 255; m_dz = 1; end
            else m_total = a / b;
`else
            m_total = 255; m_dz = 1;
`endif
          end
        endcase
      end
    end
  endtask

  task automatic step(input string tag, input int r, input int e, input int a, input int b, input int op);
    @(negedge clk);
    rst_n = r[0];
    en    = e[0];
    in1   = a[3:0];
    in2   = b[3:0];
    ops   = op[1:0];
    @(posedge clk);
    #1;
    model(r, e, a, b, op);
    chk({tag, ".total"}, {1'b0, total}, m_total[8:0]);
    chk({tag, ".valid"}, {8'b0, valid}, m_valid[8:0]);
    chk({tag, ".neg"},   {8'b0, neg},   m_neg[8:0]);
    chk({tag, ".dz"},    {8'b0, dz},    m_dz[8:0]);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in1 = '0; in2 = '0; ops = '0;

    step("rst0", 0, 1, 5, 7, 0);
    step("rst1", 0, 1, 5, 7, 0);
    step("add", 1, 1, 5, 7, 0);
    step("sub", 1, 1, 8, 3, 1);
    step("subneg", 1, 1, 3, 8, 1);
    step("addmax", 1, 1, 15, 15, 0);
    step("mul", 1, 1, 4, 6, 2);
    step("hold", 1, 0, 1, 1, 0);
    step("hold2", 1, 0, 1, 1, 0);
    step("mulmax", 1, 1, 15, 15, 2);
    step("div", 1, 1, 12, 3, 3);
    step("divfl", 1, 1, 7, 2, 3);
    step("div0", 1, 1, 9, 0, 3);
    step("subdz", 1, 1, 2, 2, 1);
    step("rsten", 0, 1, 9, 9, 2);

    for (int i = 0; i < 300; i++) begin
      int r, e;
      r = ($urandom_range(0, 19) == 0) ? 0 : 1;
      e = ($urandom_range(0, 3) == 0) ? 0 : 1;
      step("rand", r, e, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
